delay_line_ctrl: RTL

Sequencing controller for the circular-buffer delay line built on `dualportram`. It owns the write and read pointers and the RAM enables, and it accepts delay-change requests over a valid/ready handshake. It mutes the output until the buffer holds enough history for the active delay, and it applies a fixed mute window after each delay change to suppress clicks. It sits between the audio sample stream and the dual-port RAM and replaces free-running address generation.

---
 rtl/delay_pkg.sv | 30 +++
 rtl/delay_line_ctrl_sat_counter.sv | 58 +++++
 rtl/delay_line_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/delay_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : delay_pkg
//  Description : Shared types and helpers for the delay-line controller:
//                controller state encoding, default widths and the delay
//                clamp applied when a delay request is accepted.
//  Revision    : 1.0  initial release
// ============================================================================
package delay_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;

    // Width the clamp helper works in; callers zero-extend into it.
    localparam int CLAMP_W    = 32;

    typedef enum logic [1:0] {
        ST_PRIME = 2'd0,
        ST_RUN   = 2'd1,
        ST_MUTE  = 2'd2
    } state_e;

    // A zero delay would read the slot being written this sample, so it is
    // promoted to the shortest meaningful delay of one sample.
    function automatic logic [CLAMP_W-1:0] clamp_delay(input logic [CLAMP_W-1:0] req);
        return (req == '0) ? CLAMP_W'(1) : req;
    endfunction

endpackage
`default_nettype wire

// File: rtl/delay_line_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Saturating counter with synchronous load. Counts up and
//                sticks at all-ones, or (DOWN=1) counts down and sticks at 0.
//                Load has priority over counting.
//  Revision    : 1.0  initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 8,
    parameter bit DOWN  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] w_step;
    logic             w_at_limit;

    generate
        if (DOWN) begin : g_down
            assign w_step     = count_q - WIDTH'(1);
            assign w_at_limit = (count_q == '0);
        end else begin : g_up
            assign w_step     = count_q + WIDTH'(1);
            assign w_at_limit = (count_q == '1);
        end
    endgenerate

    // Next count: load wins, otherwise step unless already at the limit.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && !w_at_limit) begin
            count_d = w_step;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/delay_line_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : delay_line_ctrl
//  Description : Sequencing controller for a circular-buffer delay line on an
//                external dual-port RAM. Owns write/read pointers and RAM
//                enables, accepts delay changes over valid/ready, mutes output
//                until enough history exists and for a fixed window after
//                each delay change.
//  Revision    : 1.0  initial release
// ============================================================================
module delay_line_ctrl
    import delay_pkg::*;
#(
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int DATA_W        = DEF_DATA_W,
    parameter int DEFAULT_DELAY = 1,
    parameter int MUTE_LEN      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_en,
    input  logic [DATA_W-1:0] sample_in,
    input  logic [ADDR_W-1:0] delay_req,
    input  logic              delay_req_valid,
    output logic              delay_req_ready,
    output logic [ADDR_W-1:0] active_delay,
    output logic              ram_wr_en,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic [ADDR_W-1:0] ram_rd_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [DATA_W-1:0] out_sample,
    output logic              out_valid,
    output logic              muted
);

    localparam int MUTE_W = (MUTE_LEN < 1) ? 1 : $clog2(MUTE_LEN + 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   wp_q;
    logic [ADDR_W-1:0]   active_delay_q, active_delay_d;
    logic                rd_pend_q;
    logic                live_q;
    logic [DATA_W-1:0]   out_sample_q;
    logic                out_valid_q;

    logic [ADDR_W-1:0]   w_fill_cnt;
    logic [MUTE_W-1:0]   w_mute_cnt;
    logic                w_fill_ok;
    logic                w_handshake;
    logic                w_mute_load;
    logic                w_mute_step;
    logic                w_live;
    logic [CLAMP_W-1:0]  w_clamp_full;
    logic [ADDR_W-1:0]   w_req_clamped;

    // ------------------------------------------------------------------
    // Delay request clamp
    // ------------------------------------------------------------------
    assign w_clamp_full  = clamp_delay(CLAMP_W'(delay_req));
    assign w_req_clamped = w_clamp_full[ADDR_W-1:0];

    generate
        if (ADDR_W < CLAMP_W) begin : g_clamp_hi
            // Upper bits are always zero for a zero-extended request.
            logic w_unused_clamp_hi;
            assign w_unused_clamp_hi = ^w_clamp_full[CLAMP_W-1:ADDR_W];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Counters: history fill level and post-change mute window
    // ------------------------------------------------------------------
    sat_counter #(
        .WIDTH (ADDR_W),
        .DOWN  (1'b0)
    ) u_fill_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (sample_en),
        .load_i     (1'b0),
        .load_val_i ('0),
        .count_o    (w_fill_cnt)
    );

    sat_counter #(
        .WIDTH (MUTE_W),
        .DOWN  (1'b1)
    ) u_mute_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (w_mute_step),
        .load_i     (w_mute_load),
        .load_val_i (MUTE_W'(MUTE_LEN)),
        .count_o    (w_mute_cnt)
    );

    assign w_fill_ok       = (w_fill_cnt >= active_delay_q);
    assign delay_req_ready = (state_q != ST_MUTE);
    assign w_handshake     = delay_req_valid && delay_req_ready;
    assign w_mute_load     = w_handshake;
    assign w_mute_step     = sample_en && (state_q == ST_MUTE);

    // A sample is live if we are running, or priming and this very sample
    // completes the required history.
    assign w_live = (state_q == ST_RUN) || ((state_q == ST_PRIME) && w_fill_ok);

    // Next state and delay: strobe-driven transitions, handshake forces MUTE.
    always_comb begin
        state_d        = state_q;
        active_delay_d = active_delay_q;
        if (sample_en) begin
            case (state_q)
                ST_PRIME: if (w_fill_ok) state_d = ST_RUN;
                ST_MUTE:  if (w_mute_cnt <= MUTE_W'(1)) state_d = w_fill_ok ? ST_RUN : ST_PRIME;
                default:  state_d = state_q;
            endcase
        end
        if (w_handshake) begin
            state_d        = ST_MUTE;
            active_delay_d = w_req_clamped;
        end
    end

    // State, pointer and delay registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_PRIME;
            wp_q           <= '0;
            active_delay_q <= ADDR_W'(DEFAULT_DELAY);
        end else begin
            state_q        <= state_d;
            active_delay_q <= active_delay_d;
            if (sample_en) begin
                wp_q <= wp_q + ADDR_W'(1);
            end
        end
    end

    // Output pipeline: note the read in T, capture RAM data at end of T+1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend_q    <= 1'b0;
            live_q       <= 1'b0;
            out_sample_q <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            rd_pend_q   <= sample_en;
            out_valid_q <= rd_pend_q;
            if (sample_en) begin
                live_q <= w_live;
            end
            if (rd_pend_q) begin
                out_sample_q <= live_q ? ram_dout : '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ram_wr_en    = sample_en;
    assign ram_rd_en    = sample_en;
    assign ram_wr_addr  = wp_q;
    assign ram_rd_addr  = wp_q - active_delay_q;
    assign ram_din      = sample_in;
    assign active_delay = active_delay_q;
    assign out_sample   = out_sample_q;
    assign out_valid    = out_valid_q;
    assign muted        = (state_q != ST_RUN);

endmodule
`default_nettype wire
